// File: rtl/scc_mix_pkg.sv
// Shared constants and helpers for the N-channel SCC wavetable mixer.
//   - default parameter widths
//   - pan bit positions within each channel's 2-bit routing field
//   - volume post-shift applied to the sample x volume product
//   - constant clog2 used to size channel-index ports
package scc_mix_pkg;

  localparam int unsigned DEF_CH      = 5;
  localparam int unsigned DEF_WAVE_AW = 5;
  localparam int unsigned DEF_FREQ_W  = 12;
  localparam int unsigned DEF_OUT_W   = 12;

  localparam int unsigned SAMPLE_W  = 8;
  localparam int unsigned VOL_W     = 4;
  localparam int unsigned PROD_W    = SAMPLE_W + VOL_W;
  localparam int unsigned VOL_SHIFT = 4;

  localparam int unsigned PAN_L = 0;
  localparam int unsigned PAN_R = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/scc_wave_ram_n.sv
// Channel wave RAM: CH * 2^WAVE_AW bytes, single port, addressed {ch, a}.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset (read register only)
//   we_i            synchronous write strobe
//   re_i            read strobe; rdata_o updates on the following edge
//   addr_i          {channel, sample index}
//   wdata_i         write byte
//   rdata_o         registered read data, holds when re_i is low
module scc_wave_ram_n
  import scc_mix_pkg::*;
#(
  parameter  int unsigned CH      = DEF_CH,
  parameter  int unsigned WAVE_AW = DEF_WAVE_AW,
  localparam int unsigned CHW     = clog2(CH),
  localparam int unsigned AW      = CHW + WAVE_AW
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  output logic [SAMPLE_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = CH << WAVE_AW;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/scc_channel_mixer_n.sv
// N-channel time-multiplexed SCC wavetable mixer with stereo pan.
// A frame is CH+2 sequencer slots: slots 0..CH-1 read one sample per channel,
// the volume stage trails by one slot, accumulation by two, and slot CH+1
// folds in the last contribution and publishes the saturated L/R sums.
// Ports:
//   nreset, clk, enable       async active-low reset, clock, clock enable
//   cpu_ch/cpu_a/cpu_d        CPU wave RAM channel, index, write data
//   cpu_oe/cpu_we             CPU read/write strobes (any strobe stalls mixer)
//   cpu_q/cpu_q_en            RAM read data and its one-cycle valid
//   reg_frequency             per-channel divider reload, 0 freezes phase
//   reg_volume/enable/pan     per-channel volume, enable, {right,left} routing
//   reg_wave_reset            level; clears all phase counters and addresses
//   left_out/right_out        signed frame sums, out_valid pulses on update
//   slot                      current sequencer slot
module scc_channel_mixer_n
  import scc_mix_pkg::*;
#(
  parameter  int unsigned CH      = DEF_CH,
  parameter  int unsigned WAVE_AW = DEF_WAVE_AW,
  parameter  int unsigned FREQ_W  = DEF_FREQ_W,
  parameter  int unsigned OUT_W   = DEF_OUT_W,
  localparam int unsigned CHW     = clog2(CH)
) (
  input  logic                     nreset,
  input  logic                     clk,
  input  logic                     enable,
  input  logic [CHW-1:0]           cpu_ch,
  input  logic [WAVE_AW-1:0]       cpu_a,
  input  logic [SAMPLE_W-1:0]      cpu_d,
  input  logic                     cpu_oe,
  input  logic                     cpu_we,
  output logic [SAMPLE_W-1:0]      cpu_q,
  output logic                     cpu_q_en,
  input  logic [CH*FREQ_W-1:0]     reg_frequency,
  input  logic [CH*VOL_W-1:0]      reg_volume,
  input  logic [CH-1:0]            reg_enable,
  input  logic [CH*2-1:0]          reg_pan,
  input  logic                     reg_wave_reset,
  output logic signed [OUT_W-1:0]  left_out,
  output logic signed [OUT_W-1:0]  right_out,
  output logic                     out_valid,
  output logic [CHW:0]             slot
);

  localparam int unsigned SW     = CHW + 1;
  localparam int unsigned RAM_AW = CHW + WAVE_AW;
  localparam int unsigned ACC_W  = OUT_W + 1;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned EXT_W  = SUM_W - SAMPLE_W;

  // ---------------------------------------------------------------- control
  logic cpu_req, stall, adv;
  assign cpu_req = cpu_oe | cpu_we;
  assign stall   = enable & cpu_req;
  assign adv     = enable & ~cpu_req;

  logic [SW-1:0]  slot_q, slot_d;
  logic           last_slot, rd_slot, vol_slot, acc_slot;
  logic [CHW-1:0] rd_ch, vol_ch;

  assign last_slot = (slot_q == SW'(CH + 1));
  assign rd_slot   = (slot_q < SW'(CH));
  assign vol_slot  = (slot_q != '0) && (slot_q <= SW'(CH));
  assign acc_slot  = (slot_q >= SW'(2));
  assign rd_ch     = slot_q[CHW-1:0];
  assign vol_ch    = CHW'(slot_q - SW'(1));

  // ---------------------------------------------------------- phase state
  logic [WAVE_AW-1:0] phase_q [CH];
  logic [WAVE_AW-1:0] phase_d [CH];
  logic [FREQ_W-1:0]  cnt_q   [CH];
  logic [FREQ_W-1:0]  cnt_d   [CH];
  logic [WAVE_AW-1:0] rd_phase;

  always_comb begin
    rd_phase = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (rd_ch == CHW'(i)) rd_phase = phase_q[i];
    end
  end

  // The read uses the pre-update address; the update lands on the same edge.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < CH; i++) begin
      if (enable && reg_wave_reset) begin
        phase_d[i] = '0;
        cnt_d[i]   = '0;
      end else if (adv && rd_slot && (rd_ch == CHW'(i)) &&
                   (reg_frequency[i*FREQ_W +: FREQ_W] != '0)) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i]   = reg_frequency[i*FREQ_W +: FREQ_W];
          phase_d[i] = phase_q[i] + WAVE_AW'(1);
        end else begin
          cnt_d[i]   = cnt_q[i] - FREQ_W'(1);
        end
      end
    end
  end

  // ----------------------------------------------------------- wave RAM
  logic                ram_we, ram_re;
  logic [RAM_AW-1:0]   ram_addr;
  logic [SAMPLE_W-1:0] ram_q;

  assign ram_we   = stall & cpu_we;
  assign ram_re   = (stall & ~cpu_we) | (adv & rd_slot);
  assign ram_addr = stall ? {cpu_ch, cpu_a} : {rd_ch, rd_phase};

  scc_wave_ram_n #(
    .CH      (CH),
    .WAVE_AW (WAVE_AW)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (nreset),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (cpu_d),
    .rdata_o (ram_q)
  );

  // ------------------------------------------------------- sample capture
  // The RAM output is consumed directly when the cycle after the read does
  // not stall; if it stalls, the CPU access would clobber ram_q, so the
  // sample is parked in sample_q on that stall edge and used from there.
  logic                rd_pend_q, rd_pend_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [SAMPLE_W-1:0] vol_in;

  always_comb begin
    rd_pend_d = rd_pend_q;
    sample_d  = sample_q;
    if (enable) begin
      rd_pend_d = adv & rd_slot;
      if (rd_pend_q) sample_d = ram_q;
    end
  end

  assign vol_in = rd_pend_q ? ram_q : sample_q;

  // --------------------------------------------------------- volume stage
  logic [VOL_W-1:0] vol_sel;
  logic             en_sel;
  logic [1:0]       pan_sel;

  always_comb begin
    vol_sel = '0;
    en_sel  = 1'b0;
    pan_sel = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (vol_ch == CHW'(i)) begin
        vol_sel = reg_volume[i*VOL_W +: VOL_W];
        en_sel  = reg_enable[i];
        pan_sel = reg_pan[i*2 +: 2];
      end
    end
  end

  logic signed [PROD_W-1:0]   samp_x, vol_x, prod;
  logic signed [SAMPLE_W-1:0] cval;

  assign samp_x = {{VOL_W{vol_in[SAMPLE_W-1]}}, vol_in};
  assign vol_x  = {{SAMPLE_W{1'b0}}, vol_sel};
  assign prod   = samp_x * vol_x;
  assign cval   = SAMPLE_W'(prod >>> VOL_SHIFT);

  logic signed [SAMPLE_W-1:0] con_l_q, con_l_d, con_r_q, con_r_d;

  always_comb begin
    con_l_d = con_l_q;
    con_r_d = con_r_q;
    if (adv) begin
      con_l_d = '0;
      con_r_d = '0;
      if (vol_slot && en_sel) begin
        if (pan_sel[PAN_L]) con_l_d = cval;
        if (pan_sel[PAN_R]) con_r_d = cval;
      end
    end
  end

  // ------------------------------------------------------- accumulation
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    if (v[SUM_W-1] == v[ACC_W-1]) r = v[ACC_W-1:0];
    else if (v[SUM_W-1])          r = {1'b1, {(ACC_W-1){1'b0}}};
    else                          r = {1'b0, {(ACC_W-1){1'b1}}};
    return r;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] ext;
    logic signed [OUT_W-1:0] r;
    ext = {{(SUM_W-OUT_W){v[OUT_W-1]}}, v[OUT_W-1:0]};
    if (ext == v)       r = v[OUT_W-1:0];
    else if (v[SUM_W-1]) r = {1'b1, {(OUT_W-1){1'b0}}};
    else                 r = {1'b0, {(OUT_W-1){1'b1}}};
    return r;
  endfunction

  logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [SUM_W-1:0] sum_l, sum_r;
  logic signed [OUT_W-1:0] left_q, left_d, right_q, right_d;
  logic                    out_valid_q, out_valid_d;
  logic                    cpu_q_en_q, cpu_q_en_d;

  assign sum_l = {acc_l_q[ACC_W-1], acc_l_q} + {{EXT_W{con_l_q[SAMPLE_W-1]}}, con_l_q};
  assign sum_r = {acc_r_q[ACC_W-1], acc_r_q} + {{EXT_W{con_r_q[SAMPLE_W-1]}}, con_r_q};

  always_comb begin
    slot_d      = slot_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    left_d      = left_q;
    right_d     = right_q;
    out_valid_d = 1'b0;
    cpu_q_en_d  = enable & cpu_oe & ~cpu_we;
    if (adv) begin
      slot_d = last_slot ? '0 : slot_q + SW'(1);
      if (last_slot) begin
        left_d      = sat_out(sum_l);
        right_d     = sat_out(sum_r);
        acc_l_d     = '0;
        acc_r_d     = '0;
        out_valid_d = 1'b1;
      end else if (acc_slot) begin
        acc_l_d = sat_acc(sum_l);
        acc_r_d = sat_acc(sum_r);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < CH; i++) begin
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      slot_q      <= '0;
      rd_pend_q   <= 1'b0;
      sample_q    <= '0;
      con_l_q     <= '0;
      con_r_q     <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      left_q      <= '0;
      right_q     <= '0;
      out_valid_q <= 1'b0;
      cpu_q_en_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      rd_pend_q   <= rd_pend_d;
      sample_q    <= sample_d;
      con_l_q     <= con_l_d;
      con_r_q     <= con_r_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      left_q      <= left_d;
      right_q     <= right_d;
      out_valid_q <= out_valid_d;
      cpu_q_en_q  <= cpu_q_en_d;
    end
  end

  assign cpu_q     = ram_q;
  assign cpu_q_en  = cpu_q_en_q;
  assign left_out  = left_q;
  assign right_out = right_q;
  assign out_valid = out_valid_q;
  assign slot      = slot_q;

endmodule

// File: tb/tb_scc_channel_mixer_n.sv
// Directed bench for scc_channel_mixer_n with the default 5-channel setup.
module tb_scc_channel_mixer_n;

  localparam int unsigned CH      = 5;
  localparam int unsigned WAVE_AW = 5;
  localparam int unsigned FREQ_W  = 12;
  localparam int unsigned OUT_W   = 12;
  localparam int unsigned CHW     = 3;

  logic                    nreset, clk, enable;
  logic [CHW-1:0]          cpu_ch;
  logic [WAVE_AW-1:0]      cpu_a;
  logic [7:0]              cpu_d;
  logic                    cpu_oe, cpu_we;
  logic [7:0]              cpu_q;
  logic                    cpu_q_en;
  logic [CH*FREQ_W-1:0]    reg_frequency;
  logic [CH*4-1:0]         reg_volume;
  logic [CH-1:0]           reg_enable;
  logic [CH*2-1:0]         reg_pan;
  logic                    reg_wave_reset;
  logic signed [OUT_W-1:0] left_out, right_out;
  logic                    out_valid;
  logic [CHW:0]            slot;

  int checks = 0;
  int errors = 0;

  scc_channel_mixer_n #(
    .CH      (CH),
    .WAVE_AW (WAVE_AW),
    .FREQ_W  (FREQ_W),
    .OUT_W   (OUT_W)
  ) dut (
    .nreset         (nreset),
    .clk            (clk),
    .enable         (enable),
    .cpu_ch         (cpu_ch),
    .cpu_a          (cpu_a),
    .cpu_d          (cpu_d),
    .cpu_oe         (cpu_oe),
    .cpu_we         (cpu_we),
    .cpu_q          (cpu_q),
    .cpu_q_en       (cpu_q_en),
    .reg_frequency  (reg_frequency),
    .reg_volume     (reg_volume),
    .reg_enable     (reg_enable),
    .reg_pan        (reg_pan),
    .reg_wave_reset (reg_wave_reset),
    .left_out       (left_out),
    .right_out      (right_out),
    .out_valid      (out_valid),
    .slot           (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!out_valid && n < 64);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: no pulse after %0d cycles, required within 64", n);
    end
  endtask

  task automatic wr(input int ch, input int a, input logic [7:0] d);
    cpu_ch = CHW'(ch);
    cpu_a  = WAVE_AW'(a);
    cpu_d  = d;
    cpu_we = 1'b1;
    cyc();
    cpu_we = 1'b0;
  endtask

  task automatic fill(input int ch, input logic [7:0] d);
    for (int a = 0; a < 32; a++) wr(ch, a, d);
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) cyc();
    checks += 5;
    if (left_out !== 12'sd0) begin errors++; $display("FAIL reset_left: got %0d required 0", left_out); end
    if (right_out !== 12'sd0) begin errors++; $display("FAIL reset_right: got %0d required 0", right_out); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    if (cpu_q_en !== 1'b0) begin errors++; $display("FAIL reset_qen: got %b required 0", cpu_q_en); end
    if (slot !== 4'd0) begin errors++; $display("FAIL reset_slot: got %0d required 0", slot); end
    nreset = 1'b1;
  endtask

  task automatic test_single_channel();
    int n;
    fill(0, 8'h7F);
    reg_volume = 20'h0000F;
    reg_enable = 5'b00001;
    reg_pan    = 10'b00_00_00_00_11;
    wait_valid(n);
    wait_valid(n);
    checks += 2;
    if (left_out !== 12'sd119) begin errors++; $display("FAIL single_left: got %0d required 119", left_out); end
    if (right_out !== 12'sd119) begin errors++; $display("FAIL single_right: got %0d required 119", right_out); end
    wait_valid(n);
    checks++;
    if (n != 7) begin errors++; $display("FAIL frame_period: got %0d required 7", n); end
    // clock-enable hold mid-frame
    cyc();
    cyc();
    checks++;
    if (slot !== 4'd2) begin errors++; $display("FAIL slot_count: got %0d required 2", slot); end
    enable = 1'b0;
    repeat (4) cyc();
    checks += 2;
    if (slot !== 4'd2) begin errors++; $display("FAIL enable_hold_slot: got %0d required 2", slot); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL enable_hold_valid: got %b required 0", out_valid); end
    enable = 1'b1;
    wait_valid(n);
    checks += 2;
    if (n != 5) begin errors++; $display("FAIL enable_resume: got %0d required 5", n); end
    if (left_out !== 12'sd119) begin errors++; $display("FAIL enable_resume_left: got %0d required 119", left_out); end
  endtask

  task automatic test_all_negative();
    int n;
    for (int c = 0; c < 5; c++) fill(c, 8'h80);
    reg_volume = {5{4'd8}};
    reg_enable = 5'b11111;
    reg_pan    = {5{2'b11}};
    wait_valid(n);
    wait_valid(n);
    checks += 2;
    if (left_out !== -12'sd320) begin errors++; $display("FAIL neg_left: got %0d required -320", left_out); end
    if (right_out !== -12'sd320) begin errors++; $display("FAIL neg_right: got %0d required -320", right_out); end
  endtask

  task automatic test_pan();
    int n;
    fill(0, 8'h64);
    fill(1, 8'h40);
    reg_volume = {12'd0, 4'd15, 4'd15};
    reg_enable = 5'b00011;
    reg_pan    = {6'b0, 2'b10, 2'b01};
    wait_valid(n);
    wait_valid(n);
    checks += 2;
    if (left_out !== 12'sd93) begin errors++; $display("FAIL pan_left: got %0d required 93", left_out); end
    if (right_out !== 12'sd60) begin errors++; $display("FAIL pan_right: got %0d required 60", right_out); end
  endtask

  task automatic test_back_to_back();
    int n, m;
    wait_valid(n);
    cyc();
    cyc();
    wr(4, 0, 8'hA5);
    wr(4, 1, 8'h5A);
    wr(4, 2, 8'hC3);
    wait_valid(m);
    checks += 3;
    if (m + 5 != 10) begin errors++; $display("FAIL stall_frame_len: got %0d required 10", m + 5); end
    if (left_out !== 12'sd93) begin errors++; $display("FAIL stall_left: got %0d required 93", left_out); end
    if (right_out !== 12'sd60) begin errors++; $display("FAIL stall_right: got %0d required 60", right_out); end
    // CPU read-back, including reads landing right after a sequencer read
    cyc();
    cpu_ch = 3'd4;
    cpu_a  = 5'd0;
    cpu_oe = 1'b1;
    checks++;
    if (cpu_q_en !== 1'b0) begin errors++; $display("FAIL qen_idle: got %b required 0", cpu_q_en); end
    cyc();
    cpu_oe = 1'b0;
    checks += 2;
    if (cpu_q_en !== 1'b1) begin errors++; $display("FAIL read_qen: got %b required 1", cpu_q_en); end
    if (cpu_q !== 8'hA5) begin errors++; $display("FAIL read_data: got %h required a5", cpu_q); end
    cyc();
    checks++;
    if (cpu_q_en !== 1'b0) begin errors++; $display("FAIL read_qen_drop: got %b required 0", cpu_q_en); end
    cpu_a  = 5'd3;
    cpu_d  = 8'h3C;
    cpu_oe = 1'b1;
    cpu_we = 1'b1;
    cyc();
    cpu_we = 1'b0;
    checks++;
    if (cpu_q_en !== 1'b0) begin errors++; $display("FAIL oe_we_qen: got %b required 0", cpu_q_en); end
    cyc();
    cpu_oe = 1'b0;
    checks += 2;
    if (cpu_q_en !== 1'b1) begin errors++; $display("FAIL oe_we_readback_qen: got %b required 1", cpu_q_en); end
    if (cpu_q !== 8'h3C) begin errors++; $display("FAIL oe_we_readback: got %h required 3c", cpu_q); end
    wait_valid(n);
    checks += 2;
    if (left_out !== 12'sd93) begin errors++; $display("FAIL read_stall_left: got %0d required 93", left_out); end
    if (right_out !== 12'sd60) begin errors++; $display("FAIL read_stall_right: got %0d required 60", right_out); end
  endtask

  task automatic test_mid_reset();
    int n;
    wait_valid(n);
    repeat (3) cyc();
    #2;
    nreset = 1'b0;
    #1;
    checks += 5;
    if (left_out !== 12'sd0) begin errors++; $display("FAIL midreset_left: got %0d required 0", left_out); end
    if (right_out !== 12'sd0) begin errors++; $display("FAIL midreset_right: got %0d required 0", right_out); end
    if (slot !== 4'd0) begin errors++; $display("FAIL midreset_slot: got %0d required 0", slot); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b required 0", out_valid); end
    if (cpu_q_en !== 1'b0) begin errors++; $display("FAIL midreset_qen: got %b required 0", cpu_q_en); end
    cyc();
    nreset = 1'b1;
    wait_valid(n);
    checks += 3;
    if (n != 7) begin errors++; $display("FAIL first_valid_latency: got %0d required 7", n); end
    if (left_out !== 12'sd93) begin errors++; $display("FAIL post_reset_left: got %0d required 93", left_out); end
    if (right_out !== 12'sd60) begin errors++; $display("FAIL post_reset_right: got %0d required 60", right_out); end
  endtask

  task automatic test_ramp();
    int n, idx, exp_v;
    for (int a = 0; a < 32; a++) wr(0, a, 8'(a));
    reg_volume    = 20'h0000F;
    reg_enable    = 5'b00001;
    reg_pan       = 10'b00_00_00_00_11;
    reg_frequency = {48'd0, 12'd2};
    wait_valid(n);
    // wave reset issued while the CPU stalls the sequencer at slot 0
    cpu_ch = 3'd4;
    cpu_a  = 5'd31;
    cpu_d  = 8'h00;
    cpu_we = 1'b1;
    reg_wave_reset = 1'b1;
    cyc();
    cpu_we = 1'b0;
    reg_wave_reset = 1'b0;
    for (int f = 0; f < 100; f++) begin
      wait_valid(n);
      idx   = (f == 0) ? 0 : (((f - 1) / 3 + 1) % 32);
      exp_v = (idx * 15) >> 4;
      checks++;
      if (left_out !== 12'(exp_v)) begin
        errors++;
        $display("FAIL ramp_frame%0d: got %0d required %0d (index %0d)", f, left_out, exp_v, idx);
      end
    end
  endtask

  initial begin
    nreset         = 1'b0;
    enable         = 1'b1;
    cpu_ch         = '0;
    cpu_a          = '0;
    cpu_d          = '0;
    cpu_oe         = 1'b0;
    cpu_we         = 1'b0;
    reg_frequency  = '0;
    reg_volume     = '0;
    reg_enable     = '0;
    reg_pan        = '0;
    reg_wave_reset = 1'b0;
    test_reset();
    test_single_channel();
    test_all_negative();
    test_pan();
    test_back_to_back();
    test_mid_reset();
    test_ramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
